tangram_layer_arbiter: RTL
==========================

Name: tangram_layer_arbiter

Overview:
- Per-pixel z-order arbiter between the tangram piece renderers and the VGA output pins.
- Takes sync/vidon from the 800x600 timing generator plus a hit vector and colour from each piece; drives the RGB of the topmost hitting piece, or the background colour.
- Owns the piece z-order and accepts "raise piece to front" requests over a valid/ready handshake.
- Commits z-order changes only at frame start, so no frame tears.

Parameters:
- NUM_PIECES, 7, number of requesting pieces; 2..8.
- ID_W, 3, width of a piece id; must satisfy 2^ID_W >= NUM_PIECES.
- HL_FRAMES, 30, highlight duration in frames; used only with the optional feature.

Ports:
- clk  in  1  pixel clock (40 MHz).
- clr  in  1  reset; asynchronous, active-low (clr=0 resets).
- hsync_in  in  1  HSync from the timing generator.
- vsync_in  in  1  VSync from the timing generator.
- vidon_in  in  1  visible-area flag from the timing generator.
- frame_start  in  1  one-cycle pulse at hc=0, vc=0.
- hit  in  NUM_PIECES  bit i=1 when piece i covers the current pixel.
- color  in  12*NUM_PIECES  packed RGB444; piece i occupies bits [12i+11:12i].
- bg_color  in  12  background RGB444.
- raise_valid  in  1  raise request valid.
- raise_id  in  ID_W  piece to bring to front.
- raise_ready  out  1  arbiter can accept a request.
- rgb  out  12  registered pixel colour.
- hsync  out  1  hsync_in delayed 1 cycle.
- vsync  out  1  vsync_in delayed 1 cycle.
- top_id  out  ID_W  piece currently at the top of the z-order.
- sel_id  out  ID_W  piece that won the current pixel (registered).
- sel_valid  out  1  1 when some piece won the current pixel (registered).

Behaviour:
- Z-order storage: array zo[0..N-1]; zo[k] is the piece id at depth k, with k=N-1 as the top.
- Reset (clr=0, async):
  - zo[k]=k.
  - pending=0.
  - rgb=0, hsync=1, vsync=1, sel_id=0, sel_valid=0.
  - top_id=N-1.
- Pixel path, 1-cycle latency, all outputs registered:
  - Scan k from N-1 down to 0; the first k with hit[zo[k]]=1 wins.
  - vidon_in=0: rgb=0, sel_valid=0.
  - vidon_in=1 with a winner w: rgb=color[w], sel_id=w, sel_valid=1.
  - vidon_in=1 with no winner: rgb=bg_color, sel_valid=0, sel_id holds its previous value.
  - hsync/vsync are delayed by the same single register stage, so sync stays aligned with rgb.
- Request FSM, two states: IDLE (pending=0) and PEND (pending=1).
  - raise_ready = (state==IDLE).
  - IDLE: on raise_valid & raise_ready, latch raise_id into req_id and go to PEND.
  - PEND: on frame_start, apply req_id, return to IDLE, and raise_ready goes to 1 the next cycle.
  - Accept and frame_start in the same cycle while IDLE: the request is latched only. It is applied at the next frame_start, never in the same cycle.
- Apply rule: find p with zo[p]==req_id, then set zo[k]=zo[k+1] for p<=k<N-1 and zo[N-1]=req_id, in a single cycle.
  - If req_id is already on top: no change.
  - If req_id >= NUM_PIECES: the request is accepted, then dropped at frame_start with no change.
- top_id always equals zo[N-1]; it updates the cycle after an apply.
- Z-order changes take effect at frame_start, outside the visible area, so every frame uses a single order.
- Reset mid-frame: the pending request is discarded and the z-order returns to default immediately.

Optional Feature:
- Macro: TANGRAM_LAYER_HIGHLIGHT_EN.
- Defined:
  - An 8-bit frame counter hl_cnt loads HL_FRAMES when an apply actually changes the order, or when the applied piece is already on top.
  - hl_cnt decrements on each frame_start while nonzero; reset sets it to 0.
  - While hl_cnt != 0, the winning pixel of piece hl_id (the last applied id) is output as ~color[hl_id].
- Undefined: no counter, no inversion; the pixel path is unchanged.

Test Plan:
- Reset release, vidon_in=1, hit=0, bg_color=12'h00F: rgb=12'h00F one cycle later, top_id=6, sel_valid=0.
- hit=7'b0000011, color0=12'hF00, color1=12'h0F0: rgb=12'h0F0, sel_id=1 (piece 1 is above piece 0 by default).
- raise_id=0 accepted mid-frame: raise_ready=0 until frame_start. Then zo={1,2,3,4,5,6,0}, top_id=0, the same hit vector gives rgb=12'hF00, and raise_ready=1 again.
- raise_valid held while PEND: there is no second accept until after frame_start. raise_id=7 is accepted, and zo is unchanged after frame_start.
- Accept coinciding with frame_start: zo is unchanged at that frame_start and changes at the next one (about 663168 cycles later).
- clr pulsed low while PEND with zo modified: zo returns to default, raise_ready=1, rgb=0 asynchronously. With TANGRAM_LAYER_HIGHLIGHT_EN, raising piece 2 with color2=12'h123 outputs 12'hEDC for 30 frames, then 12'h123.

Source files
------------

// File: rtl/tangram_layer_arbiter.sv
// Per-pixel z-order arbiter: picks the topmost hitting piece and commits raise requests at frame start.
// Optional highlight inversion of the last raised piece is enabled by TANGRAM_LAYER_HIGHLIGHT_EN.
module tangram_layer_arbiter #(
    parameter int unsigned NUM_PIECES = 7,
    parameter int unsigned ID_W       = 3,
    parameter int unsigned HL_FRAMES  = 30
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     vidon_in,
    input  logic                     frame_start,
    input  logic [NUM_PIECES-1:0]    hit,
    input  logic [12*NUM_PIECES-1:0] color,
    input  logic [11:0]              bg_color,
    input  logic                     raise_valid,
    input  logic [ID_W-1:0]          raise_id,
    output logic                     raise_ready,
    output logic [11:0]              rgb,
    output logic                     hsync,
    output logic                     vsync,
    output logic [ID_W-1:0]          top_id,
    output logic [ID_W-1:0]          sel_id,
    output logic                     sel_valid
);
    localparam int unsigned NumIds = 2 ** ID_W;

    typedef enum logic {StIdle, StPend} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] req_id_q, req_id_d;
    logic [ID_W-1:0] zo_q [NUM_PIECES];
    logic [ID_W-1:0] zo_d [NUM_PIECES];
    logic [11:0]     rgb_q, rgb_d;
    logic            hsync_q, vsync_q;
    logic [ID_W-1:0] sel_id_q, sel_id_d;
    logic            sel_valid_q, sel_valid_d;

    logic [NumIds-1:0] hit_ext;
    logic [11:0]       color_arr [NumIds];
    logic              win;
    logic [ID_W-1:0]   win_id;
    logic              apply_ok;
    logic              shift;
    logic              hl_on;

    // Ids are widened to the full id space so out-of-range ids index harmlessly.
    always_comb begin
        hit_ext = NumIds'(hit);
        for (int i = 0; i < NumIds; i++) color_arr[i] = '0;
        for (int i = 0; i < NUM_PIECES; i++) color_arr[i] = color[12*i +: 12];
    end

    // Ascending scan: a later (higher-depth) hit overrides, so the topmost wins.
    always_comb begin
        win    = 1'b0;
        win_id = '0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            if (hit_ext[zo_q[k]]) begin
                win    = 1'b1;
                win_id = zo_q[k];
            end
        end
    end

    assign apply_ok = (state_q == StPend) && frame_start && (32'(req_id_q) < NUM_PIECES);

    always_comb begin
        state_d  = state_q;
        req_id_d = req_id_q;
        unique case (state_q)
            StIdle: begin
                if (raise_valid) begin
                    req_id_d = raise_id;
                    state_d  = StPend;
                end
            end
            StPend: begin
                if (frame_start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Everything from the requested piece upward slides down one slot; the piece lands on top.
    always_comb begin
        zo_d  = zo_q;
        shift = 1'b0;
        if (apply_ok) begin
            for (int k = 0; k < NUM_PIECES - 1; k++) begin
                if (zo_q[k] == req_id_q) shift = 1'b1;
                if (shift) zo_d[k] = zo_q[k+1];
            end
            zo_d[NUM_PIECES-1] = req_id_q;
        end
    end

`ifdef TANGRAM_LAYER_HIGHLIGHT_EN
    logic [7:0]      hl_cnt_q, hl_cnt_d;
    logic [ID_W-1:0] hl_id_q, hl_id_d;

    always_comb begin
        hl_cnt_d = hl_cnt_q;
        hl_id_d  = hl_id_q;
        if (apply_ok) begin
            hl_cnt_d = 8'(HL_FRAMES);
            hl_id_d  = req_id_q;
        end else if (frame_start && hl_cnt_q != 8'd0) begin
            hl_cnt_d = hl_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hl_cnt_q <= 8'd0;
            hl_id_q  <= '0;
        end else begin
            hl_cnt_q <= hl_cnt_d;
            hl_id_q  <= hl_id_d;
        end
    end

    assign hl_on = (hl_cnt_q != 8'd0) && (win_id == hl_id_q);
`else
    logic unused_hl_frames;
    assign unused_hl_frames = ^HL_FRAMES;
    assign hl_on            = 1'b0;
`endif

    always_comb begin
        rgb_d       = 12'h000;
        sel_valid_d = 1'b0;
        sel_id_d    = sel_id_q;
        if (vidon_in) begin
            if (win) begin
                rgb_d       = hl_on ? ~color_arr[win_id] : color_arr[win_id];
                sel_id_d    = win_id;
                sel_valid_d = 1'b1;
            end else begin
                rgb_d = bg_color;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            req_id_q    <= '0;
            for (int k = 0; k < NUM_PIECES; k++) zo_q[k] <= ID_W'(k);
            rgb_q       <= 12'h000;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            sel_id_q    <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_id_q    <= req_id_d;
            zo_q        <= zo_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
            sel_id_q    <= sel_id_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign raise_ready = (state_q == StIdle);
    assign top_id      = zo_q[NUM_PIECES-1];
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign sel_id      = sel_id_q;
    assign sel_valid   = sel_valid_q;

endmodule
